ahb_fir_slave_regs: RTL
=======================

// Module: ahb_fir_slave_regs
// PURPOSE
// AHB-Lite responder (slave) answering transfers from the FIR-side AHB master. Holds NREGS
// DWIDTH-bit registers: coefficients, control and status. Decodes address/control in the address
// phase and completes the data phase with optional wait states. Byte, halfword and word accesses
// use byte-lane writes. Register contents are exported to the FIR datapath.
// PARAMETERS
// DWIDTH       32  data bus width; byte lanes = DWIDTH/8
// AWIDTH       32  address bus width
// NREGS        16  number of registers, power of two; word index = haddr[2 +: $clog2(NREGS)]
// WAIT_STATES  0   hready-low cycles inserted in every data phase (0..15)
// PORTS
// clk          in   1              clock, all state on rising edge
// rst_n        in   1              reset, asynchronous, active-low
// haddr        in   AWIDTH         transfer address (address phase)
// hwrite       in   1              1 = write, 0 = read (address phase)
// hsize        in   3              0 = byte, 1 = halfword, 2 = word (address phase)
// htrans       in   2              00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
// hwdata       in   DWIDTH         write data (data phase, replicated across lanes by master)
// hready       out  1              1 = data phase completes this cycle / slave accepts new address
// hrdata       out  DWIDTH         read data, valid when hready=1 at end of a read data phase
// regs_o       out  NREGS*DWIDTH   flat register contents, reg i at [i*DWIDTH +: DWIDTH]
// wr_pulse     out  NREGS          one-cycle pulse per register written this cycle
// BEHAVIOUR
// - Reset: hready=1, hrdata=0, all registers 0, wr_pulse=0, FSM in IDLE, wait counter 0.
// - Address capture: on a rising edge with hready=1 and htrans[1]=1, latch haddr, hwrite, hsize
//   into data-phase registers and set dp_valid. IDLE/BUSY (htrans[1]=0) clear dp_valid; no action.
// - FSM: IDLE -> (valid capture) WAIT if WAIT_STATES>0, else DATA.
//   WAIT: hready=0; counter counts WAIT_STATES cycles, then -> DATA.
//   DATA: hready=1; transfer completes. A new valid capture in the same cycle pipelines into
//   WAIT/DATA; otherwise -> IDLE.
// - With WAIT_STATES=0: hready is constantly 1; single-cycle data phase; back-to-back transfers.
// - Writes commit on the edge ending the data phase (hready=1, dp_valid, dp_write).
//   Lane enables: byte  -> lane dp_addr[1:0]; halfword -> lanes {dp_addr[1],0}+{0,1};
//   word or hsize>2 -> all lanes. Unaligned halfword/word: low address bits are ignored.
// - wr_pulse[idx] is high for exactly one cycle after the committing edge.
// - Reads: hrdata = register[dp index] during the DATA cycle. It is 0 when not in a read data
//   phase, and 0 for an out-of-range index (only when NREGS < address space decoded).
// - Write then read to the same register, back-to-back: the read returns the new value (the
//   write commits before the read data phase).
// - Out-of-range address (haddr[AWIDTH-1:2+$clog2(NREGS)] != 0): write ignored, read returns 0,
//   hready timing unchanged. No error response exists.
// - htrans changes while hready=0 are ignored; address is sampled only when hready=1.
// - rst_n assertion mid-transfer aborts the transfer immediately: the write is lost, and all
//   outputs take reset values asynchronously.
// TESTING
// - Reset, then word write 0xDEADBEEF to 0x04, WAIT_STATES=0 -> hready stays 1; regs_o[1]=0xDEADBEEF;
//   wr_pulse=0x0002 for 1 cycle.
// - Byte write 0xAA (hwdata 0xAAAAAAAA) to 0x06 over reg1=0 -> reg1=0x00AA0000; halfword 0x1234
//   to 0x0A -> reg2=0x12340000.
// - Write 0x55 to 0x08, then read 0x08 on the next address phase -> hrdata=0x00000055 in the
//   following cycle with hready=1.
// - WAIT_STATES=2, read 0x00 -> hready low exactly 2 cycles, then high with hrdata=reg0;
//   a NONSEQ presented during the wait is not accepted until hready=1.
// - htrans=IDLE/BUSY with hwrite=1 -> no register change; wr_pulse=0; hrdata=0. Out-of-range
//   address 0x100 (NREGS=16): write ignored, read=0.
// - rst_n pulsed low during the WAIT of a write -> registers 0, hready=1 at once, no wr_pulse.

Source files
------------

// File: rtl/ahb_fir_slave_regs.sv
// AHB-Lite register responder for the FIR block.
// Holds NREGS DWIDTH-bit registers (coefficients, control, status), decodes the
// address phase, completes the data phase after WAIT_STATES hready-low cycles,
// applies byte-lane writes and exports the register file to the FIR datapath.
module ahb_fir_slave_regs #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 32,
    parameter int NREGS       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AWIDTH-1:0]         haddr,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [1:0]                htrans,
    input  logic [DWIDTH-1:0]         hwdata,
    output logic                      hready,
    output logic [DWIDTH-1:0]         hrdata,
    output logic [NREGS*DWIDTH-1:0]   regs_o,
    output logic [NREGS-1:0]          wr_pulse
);

    localparam int NLANES = DWIDTH / 8;
    localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int IW     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CW     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       wait_cnt;

    // Data-phase copy of the address-phase control
    logic                dp_valid;
    logic                dp_write;
    logic [2:0]          dp_size;
    logic [LW-1:0]       dp_lane;
    logic [IW-1:0]       dp_idx;
    logic                dp_oor;

    logic [DWIDTH-1:0]   regs [NREGS];

    logic                cap;
    logic                addr_oor;
    logic                wr_commit;
    logic [NLANES-1:0]   lane_en;
    logic                unused_htrans0;

    // Only htrans[1] distinguishes an active transfer; htrans[0] (SEQ vs NONSEQ, BUSY vs IDLE)
    // makes no difference to a register slave.
    assign unused_htrans0 = htrans[0];

    // Byte lanes touched by an access of the given size at the given lane offset.
    // Unaligned halfword/word accesses simply drop the low address bits.
    function automatic logic [NLANES-1:0] lane_enables(input logic [2:0]    size,
                                                       input logic [LW-1:0] lane);
        logic [NLANES-1:0] en;
        logic [LW-1:0]     base;
        en   = '0;
        base = lane & ~LW'(1);
        case (size)
            3'd0:    en[lane] = 1'b1;
            3'd1: begin
                en[base]          = 1'b1;
                en[base + LW'(1)] = 1'b1;
            end
            default: en = '1;
        endcase
        return en;
    endfunction

    // Address phase is sampled only while hready is high; IDLE/BUSY are no-ops.
    assign cap       = hready && htrans[1];
    assign addr_oor  = (haddr >> (2 + IW)) != '0;
    assign wr_commit = hready && dp_valid && dp_write && !dp_oor;
    assign lane_en   = lane_enables(dp_size, dp_lane);

    // Transfer sequencing: IDLE/DATA accept a new address, WAIT holds hready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hready   <= 1'b1;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == CW'(WAIT_STATES - 1)) begin
                        state    <= ST_DATA;
                        hready   <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    if (cap) begin
                        if (WAIT_STATES > 0) begin
                            state  <= ST_WAIT;
                            hready <= 1'b0;
                        end else begin
                            state  <= ST_DATA;
                            hready <= 1'b1;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        hready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Address-phase capture into the data-phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= '0;
            dp_lane  <= '0;
            dp_idx   <= '0;
            dp_oor   <= 1'b0;
        end else if (hready) begin
            dp_valid <= htrans[1];
            if (htrans[1]) begin
                dp_write <= hwrite;
                dp_size  <= hsize;
                dp_lane  <= haddr[LW-1:0];
                dp_idx   <= haddr[2 +: IW];
                dp_oor   <= addr_oor;
            end
        end
    end

    // Register file: lane-masked write on the edge that ends a write data phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int l = 0; l < NLANES; l++) begin
                if (lane_en[l]) begin
                    regs[dp_idx][l*8 +: 8] <= hwdata[l*8 +: 8];
                end
            end
        end
    end

    // One-cycle notification to the FIR datapath of which register changed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wr_commit) begin
                wr_pulse[dp_idx] <= 1'b1;
            end
        end
    end

    // Read data straight from the register file so a write committed on the
    // previous edge is already visible to a back-to-back read.
    always_comb begin
        hrdata = '0;
        if (hready && dp_valid && !dp_write && !dp_oor) begin
            hrdata = regs[dp_idx];
        end
    end

    // Flatten the register file for export.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_export
        assign regs_o[gi*DWIDTH +: DWIDTH] = regs[gi];
    end

endmodule
